// File: rtl/seq_reset_monitor.sv
// Watches a data stream for a fixed word sequence and issues a timed reset-request pulse.
// Define SEQRST_ARM_EN to make detection depend on the arm input.
module seq_reset_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int SEQ_LEN = 4,
  parameter logic [SEQ_LEN*DATA_WIDTH-1:0] SEQ_PATTERN = 32'h3CC355AA,
  parameter int PULSE_LEN = 4,
  parameter int HOLDOFF_LEN = 8,
  parameter int GAP_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  arm,
  output logic                  force_reset,
  output logic [3:0]            match_idx,
  output logic [7:0]            event_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TRACK   = 2'd1;
  localparam logic [1:0] PULSE   = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  localparam logic [3:0]  LAST_IDX     = 4'(SEQ_LEN - 1);
  localparam logic [7:0]  PULSE_LAST   = 8'(PULSE_LEN - 1);
  localparam logic [7:0]  HOLDOFF_LAST = (HOLDOFF_LEN > 0) ? 8'(HOLDOFF_LEN - 1) : 8'd0;
  localparam logic [15:0] GAP_LAST     = 16'(GAP_TIMEOUT - 1);

  logic [1:0]            state;
  logic [7:0]            timer;
  logic [15:0]           gap_cnt;
  logic                  armed;
  logic                  beat;
  logic [DATA_WIDTH-1:0] cur_elem;
  logic [DATA_WIDTH-1:0] first_elem;

`ifdef SEQRST_ARM_EN
  assign armed = arm;
`else
  assign armed = arm | 1'b1;
`endif

  assign beat       = data_valid & armed;
  assign first_elem = SEQ_PATTERN[DATA_WIDTH-1:0];

  always_comb begin
    cur_elem = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (match_idx == 4'(i)) cur_elem = SEQ_PATTERN[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      force_reset <= 1'b0;
      match_idx   <= 4'd0;
      event_count <= 8'd0;
      gap_cnt     <= 16'd0;
      timer       <= 8'd0;
    end else begin
      case (state)
        IDLE, TRACK: begin
          if (beat) begin
            gap_cnt <= 16'd0;
            if (data_in == cur_elem) begin
              if (match_idx == LAST_IDX) begin
                state       <= PULSE;
                force_reset <= 1'b1;
                match_idx   <= 4'd0;
                timer       <= 8'd0;
                if (event_count != 8'hFF) event_count <= event_count + 8'd1;
              end else begin
                state     <= TRACK;
                match_idx <= match_idx + 4'd1;
              end
            end else if (data_in == first_elem) begin
              // Mismatch that is itself a sequence start restarts tracking at one.
              state     <= TRACK;
              match_idx <= 4'd1;
            end else begin
              state     <= IDLE;
              match_idx <= 4'd0;
            end
          end else if (state == TRACK) begin
            if (!armed || gap_cnt == GAP_LAST) begin
              state     <= IDLE;
              match_idx <= 4'd0;
              gap_cnt   <= 16'd0;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
        end
        PULSE: begin
          if (timer == PULSE_LAST) begin
            force_reset <= 1'b0;
            timer       <= 8'd0;
            state       <= (HOLDOFF_LEN == 0) ? IDLE : HOLDOFF;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        HOLDOFF: begin
          if (timer == HOLDOFF_LAST) begin
            timer <= 8'd0;
            state <= IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_reset_monitor.sv
// Directed bench for seq_reset_monitor with default parameters (SEQRST_ARM_EN undefined).
module tb_seq_reset_monitor;

  logic       clk;
  logic       rst;
  logic       data_valid;
  logic [7:0] data_in;
  logic       arm;
  logic       force_reset;
  logic [3:0] match_idx;
  logic [7:0] event_count;

  int vecCount = 0;
  int errCount = 0;

  seq_reset_monitor dut (
    .clk(clk),
    .rst(rst),
    .data_valid(data_valid),
    .data_in(data_in),
    .arm(arm),
    .force_reset(force_reset),
    .match_idx(match_idx),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of input, then return just after the edge that sampled it.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic checkState(input string tag, input logic f, input logic [3:0] m, input logic [7:0] e);
    checkOutput({tag, ".force"}, 16'(force_reset), 16'(f));
    checkOutput({tag, ".match"}, 16'(match_idx), 16'(m));
    checkOutput({tag, ".events"}, 16'(event_count), 16'(e));
  endtask

  initial begin
    rst = 1'b1;
    data_valid = 1'b0;
    data_in = 8'h00;
    arm = 1'b1;
    #1;
    checkState("reset", 1'b0, 4'd0, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic detection, exact pulse width and exact holdoff length
    applyStimulus(1'b1, 8'hAA); checkOutput("t1.m1", 16'(match_idx), 16'd1);
    applyStimulus(1'b1, 8'h55); checkOutput("t1.m2", 16'(match_idx), 16'd2);
    applyStimulus(1'b1, 8'hC3); checkState("t1.m3", 1'b0, 4'd3, 8'd0);
    applyStimulus(1'b1, 8'h3C); checkState("t1.hit", 1'b1, 4'd0, 8'd1);
    for (int c = 2; c <= 4; c++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput("t1.pulse_hi", 16'(force_reset), 16'd1);
    end
    applyStimulus(1'b0, 8'h00); checkOutput("t1.pulse_lo", 16'(force_reset), 16'd0);
    idleCycles(7);
    applyStimulus(1'b1, 8'hAA); checkOutput("t1.holdoff_last", 16'(match_idx), 16'd0);
    applyStimulus(1'b1, 8'hAA); checkOutput("t1.after_holdoff", 16'(match_idx), 16'd1);
    applyStimulus(1'b1, 8'h00); checkOutput("t1.clear", 16'(match_idx), 16'd0);

    // Restart on a mismatch equal to the first element
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'hAA); checkOutput("t2.restart", 16'(match_idx), 16'd1);
    applyStimulus(1'b1, 8'h55); checkOutput("t2.m2", 16'(match_idx), 16'd2);
    applyStimulus(1'b1, 8'hC3);
    applyStimulus(1'b1, 8'h3C); checkState("t2.hit", 1'b1, 4'd0, 8'd2);
    idleCycles(12);

    // Gap timeout abandons the partial match
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'h55);
    idleCycles(15); checkOutput("t3.gap15", 16'(match_idx), 16'd2);
    applyStimulus(1'b0, 8'h00); checkOutput("t3.gap16", 16'(match_idx), 16'd0);
    applyStimulus(1'b1, 8'hC3);
    applyStimulus(1'b1, 8'h3C); checkState("t3.nohit", 1'b0, 4'd0, 8'd2);

    // A beat on the timeout cycle wins over the timeout
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'h55);
    idleCycles(15);
    applyStimulus(1'b1, 8'hC3); checkOutput("t3b.beat_wins", 16'(match_idx), 16'd3);
    applyStimulus(1'b1, 8'h3C); checkState("t3b.hit", 1'b1, 4'd0, 8'd3);
    idleCycles(12);

    // Second sequence during PULSE/HOLDOFF is ignored
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'hC3);
    applyStimulus(1'b1, 8'h3C); checkState("t4.hit", 1'b1, 4'd0, 8'd4);
    applyStimulus(1'b1, 8'hAA); checkOutput("t4.ign1", 16'(match_idx), 16'd0);
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'hC3); checkOutput("t4.ign3", 16'(match_idx), 16'd0);
    applyStimulus(1'b1, 8'h3C); checkState("t4.ign4", 1'b0, 4'd0, 8'd4);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput("t4.no_pulse", 16'(force_reset), 16'd0);
    end
    checkState("t4.end", 1'b0, 4'd0, 8'd4);

    // Asynchronous reset in the second cycle of PULSE
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'hC3);
    applyStimulus(1'b1, 8'h3C); checkState("t5.hit", 1'b1, 4'd0, 8'd5);
    applyStimulus(1'b0, 8'h00); checkOutput("t5.cycle2", 16'(force_reset), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    checkState("t5.async", 1'b0, 4'd0, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput("t5.no_residual", 16'(force_reset), 16'd0);
    end
    checkState("t5.end", 1'b0, 4'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
